// File: rtl/div_iter_if.sv
// Start/ready handshake and operand/result bus for the iterative divider.
interface div_iter_if #(
   parameter int DATAWIDTH = 32
);
   logic                 start;
   logic                 cancel;
   logic                 signed_op;
   logic [DATAWIDTH-1:0] dividend;
   logic [DATAWIDTH-1:0] divisor;
   logic                 ready;
   logic [DATAWIDTH-1:0] quotient;
   logic [DATAWIDTH-1:0] remainder;
   logic                 vld_out;
   logic                 div_by_zero;

   modport master (
      output start, cancel, signed_op, dividend, divisor,
      input  ready, quotient, remainder, vld_out, div_by_zero
   );

   modport slave (
      input  start, cancel, signed_op, dividend, divisor,
      output ready, quotient, remainder, vld_out, div_by_zero
   );
endinterface

// File: rtl/div_iter.sv
// Restoring divider retiring one quotient bit per clock; signed mode divides
// magnitudes and re-applies signs in FIX (truncating, remainder follows dividend).
module div_iter #(
   parameter int DATAWIDTH = 32
) (
   input logic      clk,
   input logic      rst,
   div_iter_if.slave bus
);
   localparam int CW = $clog2(DATAWIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        count;
   logic [DATAWIDTH:0]   p_acc;
   logic [DATAWIDTH-1:0] a_reg;
   logic [DATAWIDTH-1:0] b_reg;
   logic                 neg_q, neg_r;
   logic [DATAWIDTH-1:0] q_reg, r_reg;
   logic                 dbz_reg;

   logic                 accept, div_zero, last;
   logic [DATAWIDTH:0]   p_shift, p_diff;
   logic                 q_bit;
   logic [DATAWIDTH-1:0] dvd_mag, dvs_mag;

   always_comb begin
      accept   = (state == IDLE) && bus.start;
      div_zero = (bus.divisor == '0);
      last     = (count == LAST);
      // a_reg shifts out dividend bits MSB first and collects quotient bits at the LSB
      p_shift  = {p_acc[DATAWIDTH-1:0], a_reg[DATAWIDTH-1]};
      p_diff   = p_shift - {1'b0, b_reg};
      q_bit    = (p_shift >= {1'b0, b_reg});
      dvd_mag  = (bus.signed_op && bus.dividend[DATAWIDTH-1]) ? -bus.dividend : bus.dividend;
      dvs_mag  = (bus.signed_op && bus.divisor[DATAWIDTH-1])  ? -bus.divisor  : bus.divisor;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = div_zero ? DONE : CALC;
         CALC: begin
            if (bus.cancel)  state_nxt = IDLE;
            else if (last)   state_nxt = FIX;
         end
         FIX:  state_nxt = bus.cancel ? IDLE : DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         p_acc   <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         q_reg   <= '0;
         r_reg   <= '0;
         dbz_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (div_zero) begin
                     q_reg   <= '1;
                     r_reg   <= bus.dividend;
                     dbz_reg <= 1'b1;
                  end else begin
                     a_reg <= dvd_mag;
                     b_reg <= dvs_mag;
                     p_acc <= '0;
                     count <= '0;
                     neg_q <= bus.signed_op & (bus.dividend[DATAWIDTH-1] ^ bus.divisor[DATAWIDTH-1]);
                     neg_r <= bus.signed_op & bus.dividend[DATAWIDTH-1];
                  end
               end
            end
            CALC: begin
               if (!bus.cancel) begin
                  p_acc <= q_bit ? p_diff : p_shift;
                  a_reg <= {a_reg[DATAWIDTH-2:0], q_bit};
                  if (!last) count <= count + 1'b1;
               end
            end
            FIX: begin
               if (!bus.cancel) begin
                  q_reg   <= neg_q ? -a_reg : a_reg;
                  r_reg   <= neg_r ? -p_acc[DATAWIDTH-1:0] : p_acc[DATAWIDTH-1:0];
                  dbz_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready       = (state == IDLE);
   assign bus.vld_out     = (state == DONE);
   assign bus.quotient    = q_reg;
   assign bus.remainder   = r_reg;
   assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter at 32-bit and 8-bit widths: result table,
// latency/handshake timing, cancel in CALC and FIX, ignored starts, async reset.
module tb_div_iter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_iter_if #(.DATAWIDTH(32)) bus32 ();
   div_iter_if #(.DATAWIDTH(8))  bus8 ();

   div_iter #(.DATAWIDTH(32)) u_div32 (.clk(clk), .rst(rst), .bus(bus32));
   div_iter #(.DATAWIDTH(8))  u_div8  (.clk(clk), .rst(rst), .bus(bus8));

   logic        sel;
   logic        st, sop, cnc;
   logic [31:0] dvd, dvs;

   assign bus32.start     = st & ~sel;
   assign bus32.cancel    = cnc & ~sel;
   assign bus32.signed_op = sop;
   assign bus32.dividend  = dvd;
   assign bus32.divisor   = dvs;
   assign bus8.start      = st & sel;
   assign bus8.cancel     = cnc & sel;
   assign bus8.signed_op  = sop;
   assign bus8.dividend   = dvd[7:0];
   assign bus8.divisor    = dvs[7:0];

   logic        rdy, vld, dbz;
   logic [31:0] q, r;
   always_comb begin
      rdy = sel ? bus8.ready : bus32.ready;
      vld = sel ? bus8.vld_out : bus32.vld_out;
      dbz = sel ? bus8.div_by_zero : bus32.div_by_zero;
      q   = sel ? {24'b0, bus8.quotient}  : bus32.quotient;
      r   = sel ? {24'b0, bus8.remainder} : bus32.remainder;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } vec_t;

   vec_t tbl [11];

   task automatic run_op(input bit w8, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                         input logic ed, input bit noise, input string tag);
      int  lat;
      bit  busy_bad;
      lat = 0;
      busy_bad = 1'b0;
      sel = w8;
      @(negedge clk);
      st = 1'b1; sop = s; dvd = a; dvs = b;
      @(negedge clk);
      st = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         if (rdy) busy_bad = 1'b1;
         if (vld) begin
            lat = c;
            break;
         end
         if (noise && c == 3) begin
            st = 1'b1; dvd = 32'd1000; dvs = 32'd10;
         end
         if (noise && c == 4) st = 1'b0;
         @(negedge clk);
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " ready_low"}, {31'b0, busy_bad}, 32'd0);
      check({tag, " quotient"}, q, eq);
      check({tag, " remainder"}, r, er);
      check({tag, " div_by_zero"}, {31'b0, dbz}, {31'b0, ed});
      if (noise) st = 1'b1;
      @(negedge clk);
      st = 1'b0;
      check({tag, " ready_vld_after"}, {30'b0, rdy, vld}, 32'd2);
   endtask

   task automatic run_cancel(input int k, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] pq, input logic [31:0] pr, input string tag);
      bit bad;
      int vcount;
      bad = 1'b0;
      vcount = 0;
      sel = 1'b0;
      @(negedge clk);
      st = 1'b1; sop = 1'b0; dvd = a; dvs = b;
      @(negedge clk);
      st = 1'b0;
      for (int c = 1; c < k; c++) begin
         if (c == 3) begin
            st = 1'b1; dvd = 32'd1000; dvs = 32'd10;
         end
         if (c == 4) st = 1'b0;
         if (vld || rdy) bad = 1'b1;
         @(negedge clk);
      end
      cnc = 1'b1;
      @(negedge clk);
      cnc = 1'b0;
      check({tag, " busy_before_cancel"}, {31'b0, bad}, 32'd0);
      check({tag, " ready_vld_after"}, {30'b0, rdy, vld}, 32'd2);
      check({tag, " quotient_kept"}, q, pq);
      check({tag, " remainder_kept"}, r, pr);
      check({tag, " dbz_kept"}, {31'b0, dbz}, 32'd0);
      for (int c = 0; c < 40; c++) begin
         if (vld) vcount++;
         @(negedge clk);
      end
      check({tag, " no_vld"}, vcount, 32'd0);
   endtask

   initial begin
      tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
      tbl[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
      tbl[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
      tbl[4]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
      tbl[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
      tbl[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
      tbl[7]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
      tbl[8]  = '{1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          1'b0};
      tbl[9]  = '{1'b0, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0};
      tbl[10] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};

      sel = 1'b0; st = 1'b0; sop = 1'b0; cnc = 1'b0; dvd = '0; dvs = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset ready_vld", {30'b0, rdy, vld}, 32'd2);
      check("reset quotient", q, 32'd0);
      check("reset remainder", r, 32'd0);
      check("reset dbz", {31'b0, dbz}, 32'd0);

      for (int i = 0; i < 11; i++)
         run_op(1'b0, tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].dbz ? 1 : 34,
                tbl[i].q, tbl[i].r, tbl[i].dbz, 1'b0, $sformatf("vec%0d", i));

      run_cancel(10, 32'd100, 32'd7, 32'd14, 32'hFFFF_FFFE, "cancel_calc");
      run_op(1'b0, 1'b0, 32'd50, 32'd6, 34, 32'd8, 32'd2, 1'b0, 1'b1, "after_cancel");
      run_cancel(33, 32'd9, 32'd3, 32'd8, 32'd2, "cancel_fix");

      run_op(1'b1, 1'b0, 32'd200, 32'd3, 10, 32'd66, 32'd2, 1'b0, 1'b0, "w8_200_3");
      run_op(1'b1, 1'b1, 32'h80, 32'h03, 10, 32'hD6, 32'hFE, 1'b0, 1'b0, "w8_signed_min");
      run_op(1'b1, 1'b0, 32'h2A, 32'h00, 1, 32'hFF, 32'h2A, 1'b1, 1'b0, "w8_zero");

      sel = 1'b1;
      @(negedge clk);
      st = 1'b1; sop = 1'b0; dvd = 32'd200; dvs = 32'd3;
      @(negedge clk);
      st = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("w8_rst ready_vld", {30'b0, rdy, vld}, 32'd2);
      check("w8_rst quotient", q, 32'd0);
      check("w8_rst remainder", r, 32'd0);
      check("w8_rst dbz", {31'b0, dbz}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
